// File: rtl/mips_instr_loader_if.sv
// Record-in / IMEM-write-out bundle for the instruction loader.
// Latency: n/a (wires only).
// Backpressure: in_ready is driven by the loader; the source holds in_valid and the fields until accepted.
interface mips_instr_loader_if #(
    parameter int ADDR_W = 8
);
    // Session control
    logic              start;
    logic [ADDR_W-1:0] base_addr;

    // Record stream
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [3:0]        in_kind;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [4:0]        in_shamt;
    logic [5:0]        in_funct;
    logic [15:0]       in_imm;
    logic [25:0]       in_target;

    // IMEM write port
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    // Status
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   count;
    logic              err_illegal;
    logic              err_overflow;

    modport master (
        output start, base_addr, in_valid, in_last, in_kind, in_rs, in_rt, in_rd,
               in_shamt, in_funct, in_imm, in_target,
        input  in_ready, imem_we, imem_addr, imem_wdata, busy, done, count,
               err_illegal, err_overflow
    );

    modport slave (
        input  start, base_addr, in_valid, in_last, in_kind, in_rs, in_rt, in_rd,
               in_shamt, in_funct, in_imm, in_target,
        output in_ready, imem_we, imem_addr, imem_wdata, busy, done, count,
               err_illegal, err_overflow
    );
endinterface

// File: rtl/mips_instr_loader.sv
// Encodes decoded instruction records into MIPS words and writes them to consecutive IMEM addresses.
// Latency: record accepted at edge K -> IMEM write strobe during cycle K+1; one record per cycle.
// Backpressure: in_ready only in LOAD while count < DEPTH; it never depends on in_valid.
module mips_instr_loader #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic                clock,
    input  logic                reset_n,
    mips_instr_loader_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

    // Opcode per instruction class; must track the control decoder's opcode set.
    function automatic logic [5:0] opcode_of(input logic [3:0] kind);
        logic [5:0] op;
        case (kind)
            4'd0:    op = 6'b000000; // R-type
            4'd1:    op = 6'b100011; // lw
            4'd2:    op = 6'b101011; // sw
            4'd3:    op = 6'b000100; // beq
            4'd4:    op = 6'b000010; // j
            4'd5:    op = 6'b001000; // addi
            4'd6:    op = 6'b001100; // andi
            4'd7:    op = 6'b001101; // ori
            4'd8:    op = 6'b001010; // slti
            4'd9:    op = 6'b100000; // lb
            4'd10:   op = 6'b100001; // lh
            4'd11:   op = 6'b101000; // sb
            4'd12:   op = 6'b101001; // sh
            default: op = 6'b000000;
        endcase
        return op;
    endfunction

    state_t            state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              err_ill_q, err_ill_d;
    logic              err_ovf_q, err_ovf_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              busy_q, done_q;

    logic              in_ready;
    logic              accept;
    logic              legal;
    logic [5:0]        op;
    logic [31:0]       enc_word;

    // Handshake and field encoding for the record currently presented.
    always_comb begin
        in_ready = (state_q == ST_LOAD) && (count_q < DEPTH_C);
        accept   = bus.in_valid && in_ready;
        legal    = (bus.in_kind <= 4'd12);
        op       = opcode_of(bus.in_kind);
        enc_word = {op, bus.in_rs, bus.in_rt, bus.in_imm};
        if (bus.in_kind == 4'd0) begin
            enc_word = {op, bus.in_rs, bus.in_rt, bus.in_rd, bus.in_shamt, bus.in_funct};
        end else if (bus.in_kind == 4'd4) begin
            enc_word = {op, bus.in_target};
        end
    end

    // Session FSM next state, write generation and counters.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        base_d    = base_q;
        err_ill_d = err_ill_q;
        err_ovf_d = err_ovf_q;
        we_d      = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d   = ST_LOAD;
                    base_d    = bus.base_addr;
                    count_d   = '0;
                    err_ill_d = 1'b0;
                    err_ovf_d = 1'b0;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    if (legal) begin
                        we_d    = 1'b1;
                        addr_d  = base_q + count_q[ADDR_W-1:0];
                        wdata_d = enc_word;
                        count_d = count_q + ONE_C;
                    end else begin
                        err_ill_d = 1'b1;
                    end
                    if (bus.in_last) begin
                        state_d = ST_DONE;
                    end else if (legal && (count_q + ONE_C == DEPTH_C)) begin
                        // Full session without an end marker: still write it, but flag it.
                        state_d   = ST_DONE;
                        err_ovf_d = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                // start is deliberately ignored here, including on the exit cycle.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any pending write.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            base_q    <= '0;
            err_ill_q <= 1'b0;
            err_ovf_q <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            base_q    <= base_d;
            err_ill_q <= err_ill_d;
            err_ovf_q <= err_ovf_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            busy_q    <= (state_d != ST_IDLE);
            done_q    <= (state_d == ST_DONE);
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.imem_we      = we_q;
    assign bus.imem_addr    = addr_q;
    assign bus.imem_wdata   = wdata_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.count        = count_q;
    assign bus.err_illegal  = err_ill_q;
    assign bus.err_overflow = err_ovf_q;

endmodule

// File: tb/tb_mips_instr_loader.sv
// Directed bench for the instruction loader: a default-size instance plus a tiny DEPTH=4/ADDR_W=2 instance.
// Latency: writes expected one cycle after acceptance, back-to-back.
// Backpressure: records are held until in_ready is seen at the falling edge.
module tb_mips_instr_loader;

    logic clock;
    logic reset_n;
    int   checks;
    int   failures;
    int   cyc;

    mips_instr_loader_if #(.ADDR_W(8)) bus ();
    mips_instr_loader_if #(.ADDR_W(2)) bus2 ();

    mips_instr_loader #(.ADDR_W(8), .DEPTH(256)) u_dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    mips_instr_loader #(.ADDR_W(2), .DEPTH(4)) u_dut2 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus2.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Write logs, sampled mid-cycle.
    logic [7:0]  wa[$];
    logic [31:0] wd[$];
    int          wc[$];
    logic [1:0]  wa2[$];
    logic [31:0] wd2[$];

    always @(negedge clock) begin
        if (bus.imem_we) begin
            wa.push_back(bus.imem_addr);
            wd.push_back(bus.imem_wdata);
            wc.push_back(cyc);
        end
        if (bus2.imem_we) begin
            wa2.push_back(bus2.imem_addr);
            wd2.push_back(bus2.imem_wdata);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the accepting edge.
    task automatic send(input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [5:0] fn, input logic [15:0] imm,
                        input logic [25:0] tgt, input logic last);
        int n;
        bus.in_kind   = k;
        bus.in_rs     = rs;
        bus.in_rt     = rt;
        bus.in_rd     = rd;
        bus.in_shamt  = 5'd0;
        bus.in_funct  = fn;
        bus.in_imm    = imm;
        bus.in_target = tgt;
        bus.in_last   = last;
        bus.in_valid  = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 16) begin
            @(negedge clock);
            n++;
        end
        check("send_ready", bus.in_ready, 1);
        @(posedge clock);
        @(negedge clock);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic pulse_start(input logic [7:0] b);
        bus.start     = 1'b1;
        bus.base_addr = b;
        @(negedge clock);
        bus.start     = 1'b0;
    endtask

    // Hard stop in case a wait is never satisfied.
    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        int s0;
        int gap;
        checks   = 0;
        failures = 0;
        cyc      = 0;
        reset_n  = 1'b0;
        bus.start = 1'b0;  bus.base_addr = '0; bus.in_valid = 1'b0; bus.in_last = 1'b0;
        bus.in_kind = '0;  bus.in_rs = '0; bus.in_rt = '0; bus.in_rd = '0; bus.in_shamt = '0;
        bus.in_funct = '0; bus.in_imm = '0; bus.in_target = '0;
        bus2.start = 1'b0; bus2.base_addr = '0; bus2.in_valid = 1'b0; bus2.in_last = 1'b0;
        bus2.in_kind = '0; bus2.in_rs = '0; bus2.in_rt = '0; bus2.in_rd = '0; bus2.in_shamt = '0;
        bus2.in_funct = '0; bus2.in_imm = '0; bus2.in_target = '0;

        // ---- Reset state ----
        repeat (3) @(negedge clock);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_we", bus.imem_we, 0);
        check("rst_addr", bus.imem_addr, 0);
        check("rst_wdata", bus.imem_wdata, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_count", bus.count, 0);
        check("rst_errs", {bus.err_illegal, bus.err_overflow}, 0);
        reset_n = 1'b1;
        @(negedge clock);
        check("idle_in_ready", bus.in_ready, 0);

        // ---- Basic encode, back-to-back ----
        wa.delete(); wd.delete(); wc.delete();
        pulse_start(8'h10);
        check("t1_busy", bus.busy, 1);
        check("t1_ready", bus.in_ready, 1);
        check("t1_count0", bus.count, 0);
        send(4'd5, 5'd0, 5'd8, 5'd0, 6'h00, 16'h0005, 26'h0, 1'b0);
        send(4'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'h0000, 26'h0, 1'b0);
        send(4'd1, 5'd29, 5'd9, 5'd0, 6'h00, 16'h0004, 26'h0, 1'b0);
        send(4'd4, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0000, 26'h10, 1'b1);
        check("t1_done", bus.done, 1);
        check("t1_last_we", bus.imem_we, 1);
        check("t1_busy_done", bus.busy, 1);
        check("t1_ready_done", bus.in_ready, 0);
        @(negedge clock);
        check("t1_done_gone", bus.done, 0);
        check("t1_busy_gone", bus.busy, 0);
        check("t1_count", bus.count, 4);
        check("t1_errs", {bus.err_illegal, bus.err_overflow}, 0);
        check("t1_nwrites", wa.size(), 4);
        if (wa.size() == 4) begin
            check("t1_a0", {wa[0], wd[0]}, {8'h10, 32'h20080005});
            check("t1_a1", {wa[1], wd[1]}, {8'h11, 32'h00221820});
            check("t1_a2", {wa[2], wd[2]}, {8'h12, 32'h8FA90004});
            check("t1_a3", {wa[3], wd[3]}, {8'h13, 32'h08000010});
            check("t1_b2b", wc[3] - wc[0], 3);
        end

        // ---- Handshake gaps ----
        wa.delete(); wd.delete();
        pulse_start(8'h20);
        gap = $urandom_range(2, 5);
        bus.in_kind = 4'd3; bus.in_imm = 16'hFFFF;
        for (int i = 0; i < gap; i++) @(negedge clock);
        check("t2_no_early_write", wa.size(), 0);
        check("t2_count_gap", bus.count, 0);
        send(4'd3, 5'd1, 5'd2, 5'd0, 6'h00, 16'hFFFF, 26'h0, 1'b1);
        repeat (4) @(negedge clock);
        check("t2_nwrites", wa.size(), 1);
        if (wa.size() == 1) check("t2_w0", {wa[0], wd[0]}, {8'h20, 32'h1022FFFF});
        check("t2_count", bus.count, 1);

        // ---- Illegal class ----
        wa.delete(); wd.delete();
        pulse_start(8'h30);
        send(4'd14, 5'd3, 5'd3, 5'd3, 6'h3F, 16'h1234, 26'h0, 1'b0);
        check("t3_ill_no_we", bus.imem_we, 0);
        check("t3_ill_count", bus.count, 0);
        check("t3_ill_flag", bus.err_illegal, 1);
        send(4'd7, 5'd0, 5'd4, 5'd0, 6'h00, 16'h00FF, 26'h0, 1'b1);
        check("t3_done", bus.done, 1);
        repeat (2) @(negedge clock);
        check("t3_nwrites", wa.size(), 1);
        if (wa.size() == 1) check("t3_w0", {wa[0], wd[0]}, {8'h30, 32'h340400FF});
        check("t3_count", bus.count, 1);
        check("t3_ill_hold", bus.err_illegal, 1);

        // ---- Start clears error; start while busy is ignored ----
        wa.delete(); wd.delete();
        pulse_start(8'h50);
        check("t6_ill_cleared", bus.err_illegal, 0);
        send(4'd5, 5'd0, 5'd8, 5'd0, 6'h00, 16'h0005, 26'h0, 1'b0);
        pulse_start(8'h40);
        check("t6_count_kept", bus.count, 1);
        check("t6_busy", bus.busy, 1);
        check("t6_ready", bus.in_ready, 1);
        send(4'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'h0000, 26'h0, 1'b1);
        repeat (2) @(negedge clock);
        check("t6_nwrites", wa.size(), 2);
        if (wa.size() == 2) begin
            check("t6_w0", {wa[0], wd[0]}, {8'h50, 32'h20080005});
            check("t6_w1", {wa[1], wd[1]}, {8'h51, 32'h00221820});
        end

        // ---- Overflow and wrap on the small instance ----
        wa2.delete(); wd2.delete();
        bus2.start = 1'b1; bus2.base_addr = 2'd3;
        @(negedge clock);
        bus2.start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus2.in_valid = 1'b1;
            bus2.in_kind  = 4'd7;
            bus2.in_imm   = 16'(i);
            check($sformatf("t4_ready_%0d", i), bus2.in_ready, (i < 4) ? 1 : 0);
            if (i == 4) begin
                check("t4_done", bus2.done, 1);
                check("t4_ovf", bus2.err_overflow, 1);
                check("t4_count", bus2.count, 4);
            end
            @(negedge clock);
        end
        bus2.in_valid = 1'b0;
        check("t4_ovf_hold", bus2.err_overflow, 1);
        check("t4_idle", bus2.busy, 0);
        check("t4_nwrites", wa2.size(), 4);
        if (wa2.size() == 4) begin
            check("t4_w0", {wa2[0], wd2[0]}, {2'd3, 32'h34000000});
            check("t4_w1", {wa2[1], wd2[1]}, {2'd0, 32'h34000001});
            check("t4_w2", {wa2[2], wd2[2]}, {2'd1, 32'h34000002});
            check("t4_w3", {wa2[3], wd2[3]}, {2'd2, 32'h34000003});
        end

        // ---- Reset mid-session ----
        wa.delete(); wd.delete();
        pulse_start(8'h60);
        send(4'd6, 5'd1, 5'd1, 5'd0, 6'h00, 16'h000F, 26'h0, 1'b0);
        send(4'd8, 5'd2, 5'd2, 5'd0, 6'h00, 16'h0010, 26'h0, 1'b0);
        check("t5_pending_we", bus.imem_we, 1);
        #2 reset_n = 1'b0;
        #1;
        s0 = wa.size();
        check("t5_writes_before", s0, 2);
        check("t5_we", bus.imem_we, 0);
        check("t5_addr", bus.imem_addr, 0);
        check("t5_wdata", bus.imem_wdata, 0);
        check("t5_busy", bus.busy, 0);
        check("t5_count", bus.count, 0);
        check("t5_ready", bus.in_ready, 0);
        @(negedge clock);
        reset_n = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_kind  = 4'd5;
        repeat (3) @(negedge clock);
        check("t5_idle_ready", bus.in_ready, 0);
        check("t5_no_trailing", wa.size(), s0);
        bus.in_valid = 1'b0;
        pulse_start(8'h00);
        check("t5_resume_ready", bus.in_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
